legv8_control_sequencer: RTL and testbench
==========================================

# legv8_control_sequencer

Multi-cycle LEGv8 control unit that produces the 94-bit control word consumed by the datapath. It latches each instruction from the instruction ROM, decodes it, and steps a small state machine that sequences register, ALU, memory and program-counter actions. It reads the datapath's 5-bit status back for conditional branches. It sits between the ROM output and the datapath control-word input.

## Interface
- `HALT_ON_ILLEGAL`, default 1: 1 means an undecoded opcode enters HALT; 0 means it executes as a NOP.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low.
- `instruction` input 32: ROM word at the current PC.
- `status` input 5: bits [4:1] are registered flags {V,C,N,Z}; bit [0] is live ALU zero.
- `control_word` output 94: {constant[93:30], EN_PC 29, EN_Mem 28, EN_ALU 27, PCsel 26, Bsel 25, SL 24, WM 23, WR 22, PS[21:20], FS[19:15], SB[14:10], SA[9:5], DA[4:0]}.
- `illegal` output 1: sticky; set when an undecoded opcode is seen.
- `halted` output 1: high while in HALT.

## Operation
- States are FETCH, EXEC, EXEC2, HALT.
- FETCH
  - Capture `instruction` into IR.
  - Drive the NOP word: all 94 bits 0, so PS=00 holds the PC.
  - Next state is EXEC.
- PS encoding: 00 = hold, 01 = PC+4, 10 = PC←A bus, 11 = PC←PC+constant.
- FS encoding is {op[2:0], invB, cin}, with op 000 AND, 001 ORR, 010 ADD, 100 pass-B.
  - ADD = 01000, SUB = 01011, AND = 00000, ORR = 00100, PASSB = 10000.
- Each EXEC action below then returns to FETCH unless stated.
  - ADD/SUB/AND/ORR (R-type), ADDS/SUBS: DA=Rd, SA=Rn, SB=Rm, EN_ALU=1, WR=1, PS=01. SL=1 only for ADDS/SUBS.
  - ADDI/SUBI: Bsel=1, constant = zero-extended imm12, otherwise as R-type.
  - MOVZ: Bsel=1, constant = imm16 << (16·hw), FS=PASSB, EN_ALU=1, WR=1, DA=Rd, PS=01.
  - LDUR: SA=Rn, Bsel=1, constant = sign-extended addr9, FS=ADD, EN_Mem=1, WR=1, DA=Rt, PS=01.
  - STUR: same address path as LDUR, SB=Rt, WM=1, WR=0, PS=01.
  - B: constant = sign-extended imm26<<2, PS=11.
  - BR: SA=Rn, PCsel=0, PS=10.
  - BL, first cycle: EN_PC=1, DA=30, WR=1, PS=00, then go to EXEC2. EXEC2: PS=11 with imm26 offset.
  - CBZ/CBNZ, first cycle: SB=Rt, FS=PASSB, EN_ALU=0, WR=0, PS=00. Latch `status[0]` into zlat, then go to EXEC2.
    - EXEC2: PS=11 with constant = sign-extended imm19<<2 if (CBZ and zlat) or (CBNZ and !zlat). Otherwise PS=01.
  - B.cond: evaluate cond[3:0] against `status[4:1]` sampled in EXEC. PS=11 (imm19<<2) if taken, else PS=01.
    - Codes 0–13 are EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
    - Codes 14 and 15 are always taken.
  - Undecoded opcode: set `illegal`. Go to HALT if `HALT_ON_ILLEGAL`; otherwise issue PS=01 and return to FETCH.
- HALT drives the NOP word and stays there until reset.
- The decode priority is by opcode width: 11-bit, then 10, 9, 8, 6.

## Timing
- Reset values: state=FETCH, IR=0, zlat=0, `illegal`=0, `halted`=0, `control_word`=0.
- Reset asserted mid-instruction aborts immediately. No partial writes occur after assertion.
- `control_word` is a combinational function of registered state, IR and zlat only.
  - Exception: the B.cond taken-decision also uses `status[4:1]`, which is registered in the datapath.
  - There is no combinational path from `status[0]`.
- Latency in cycles:
  - 2 for ALU, immediate, MOVZ, LDUR, STUR, B, BR and B.cond.
  - 3 for BL and CB*.
- SL=1 in a given EXEC means flags are visible to the next instruction's EXEC.
- All offset arithmetic is 64-bit two's-complement. Wrap-around is allowed.

## Structure
- Shared package `legv8_pkg` holds:
  - opcode constants
  - FS/PS encodings
  - control-word field offsets
  - state enum
  - condition codes
- One natural sub-module, `legv8_cond_eval`: a combinational cond[3:0] × flags → taken evaluator.

## Test plan
- Reset release with ROM `ADDI X1,X31,#5` (0x910017E1) -> FETCH word = 0. EXEC word: DA=1, SA=31, Bsel=1, constant=5, FS=01000, WR=1, PS=01.
- `SUBS X2,X1,X1` -> SL=1, FS=01011. A following `B.EQ #+8` with status[1]=1 -> PS=11, constant=8. The same instruction with status[1]=0 -> PS=01.
- `CBZ X3,#-4`:
  - With status[0]=1 in the first EXEC cycle -> EXEC2 PS=11, constant=0xFFFF_FFFF_FFFF_FFFC.
  - With status[0]=0 -> PS=01.
- `BL #+16` -> cycle 1: EN_PC=1, DA=30, WR=1, PS=00. Cycle 2: PS=11, constant=16.
- `STUR X4,[X5,#-8]` -> SA=5, SB=4, Bsel=1, constant=−8, WM=1, WR=0.
- Opcode 0xFFFFFFFF:
  - With `HALT_ON_ILLEGAL`=1 -> `illegal`=1, `halted`=1, word stays 0.
  - Asserting `reset` low mid-BL -> next observed word = 0, state FETCH.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcodes, ALU/PC select encodings, control-word layout,
// sequencer states, condition codes and the width-prioritised opcode decoder.
package legv8_pkg;

    typedef enum logic [1:0] {StFetch, StExec, StExec2, StHalt} state_e;

    typedef enum logic [4:0] {
        OpAdd, OpSub, OpAnd, OpOrr, OpAdds, OpSubs, OpLdur, OpStur, OpBr,
        OpAddi, OpSubi, OpMovz, OpCbz, OpCbnz, OpBcond, OpB, OpBl, OpIllegal
    } op_e;

    typedef enum logic [3:0] {
        CondEq, CondNe, CondHs, CondLo, CondMi, CondPl, CondVs, CondVc,
        CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
    } cond_e;

    localparam logic [10:0] OpcAdd   = 11'h458;
    localparam logic [10:0] OpcSub   = 11'h658;
    localparam logic [10:0] OpcAnd   = 11'h450;
    localparam logic [10:0] OpcOrr   = 11'h550;
    localparam logic [10:0] OpcAdds  = 11'h558;
    localparam logic [10:0] OpcSubs  = 11'h758;
    localparam logic [10:0] OpcLdur  = 11'h7C2;
    localparam logic [10:0] OpcStur  = 11'h7C0;
    localparam logic [10:0] OpcBr    = 11'h6B0;
    localparam logic [9:0]  OpcAddi  = 10'h244;
    localparam logic [9:0]  OpcSubi  = 10'h344;
    localparam logic [8:0]  OpcMovz  = 9'h1A5;
    localparam logic [7:0]  OpcCbz   = 8'hB4;
    localparam logic [7:0]  OpcCbnz  = 8'hB5;
    localparam logic [7:0]  OpcBcond = 8'h54;
    localparam logic [5:0]  OpcB     = 6'h05;
    localparam logic [5:0]  OpcBl    = 6'h25;

    // FS = {op[2:0], invB, cin}
    localparam logic [4:0] FsAnd   = 5'b00000;
    localparam logic [4:0] FsOrr   = 5'b00100;
    localparam logic [4:0] FsAdd   = 5'b01000;
    localparam logic [4:0] FsSub   = 5'b01011;
    localparam logic [4:0] FsPassB = 5'b10000;

    localparam logic [1:0] PsHold = 2'b00;
    localparam logic [1:0] PsInc  = 2'b01;
    localparam logic [1:0] PsReg  = 2'b10;
    localparam logic [1:0] PsRel  = 2'b11;

    localparam int unsigned CwDaLsb    = 0;
    localparam int unsigned CwSaLsb    = 5;
    localparam int unsigned CwSbLsb    = 10;
    localparam int unsigned CwFsLsb    = 15;
    localparam int unsigned CwPsLsb    = 20;
    localparam int unsigned CwWr       = 22;
    localparam int unsigned CwWm       = 23;
    localparam int unsigned CwSl       = 24;
    localparam int unsigned CwBsel     = 25;
    localparam int unsigned CwPcsel    = 26;
    localparam int unsigned CwEnAlu    = 27;
    localparam int unsigned CwEnMem    = 28;
    localparam int unsigned CwEnPc     = 29;
    localparam int unsigned CwConstLsb = 30;
    localparam int unsigned CwWidth    = 94;

    typedef struct packed {
        logic [63:0] k;
        logic        en_pc;
        logic        en_mem;
        logic        en_alu;
        logic        pcsel;
        logic        bsel;
        logic        sl;
        logic        wm;
        logic        wr;
        logic [1:0]  ps;
        logic [4:0]  fs;
        logic [4:0]  sb;
        logic [4:0]  sa;
        logic [4:0]  da;
    } ctrl_t;

    // Narrow opcodes are tested first so a wider match overrides them.
    function automatic op_e decode_op(input logic [31:0] ir);
        op_e op;
        op = OpIllegal;
        case (ir[31:26])
            OpcB:    op = OpB;
            OpcBl:   op = OpBl;
            default: ;
        endcase
        case (ir[31:24])
            OpcCbz:   op = OpCbz;
            OpcCbnz:  op = OpCbnz;
            OpcBcond: op = OpBcond;
            default:  ;
        endcase
        if (ir[31:23] == OpcMovz) op = OpMovz;
        case (ir[31:22])
            OpcAddi: op = OpAddi;
            OpcSubi: op = OpSubi;
            default: ;
        endcase
        case (ir[31:21])
            OpcAdd:  op = OpAdd;
            OpcSub:  op = OpSub;
            OpcAnd:  op = OpAnd;
            OpcOrr:  op = OpOrr;
            OpcAdds: op = OpAdds;
            OpcSubs: op = OpSubs;
            OpcLdur: op = OpLdur;
            OpcStur: op = OpStur;
            OpcBr:   op = OpBr;
            default: ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// Combinational B.cond evaluator: condition code against registered {V,C,N,Z} flags.
module legv8_cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);
    logic v, c, n, z;

    assign {v, c, n, z} = flags_i;

    always_comb begin
        taken_o = 1'b0;
        unique case (cond_e'(cond_i))
            CondEq: taken_o = z;
            CondNe: taken_o = !z;
            CondHs: taken_o = c;
            CondLo: taken_o = !c;
            CondMi: taken_o = n;
            CondPl: taken_o = !n;
            CondVs: taken_o = v;
            CondVc: taken_o = !v;
            CondHi: taken_o = c && !z;
            CondLs: taken_o = !(c && !z);
            CondGe: taken_o = (n == v);
            CondLt: taken_o = (n != v);
            CondGt: taken_o = !z && (n == v);
            CondLe: taken_o = !(!z && (n == v));
            CondAl: taken_o = 1'b1;
            CondNv: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_control_sequencer.sv
// Multi-cycle LEGv8 control unit: latches the ROM word in FETCH and emits one 94-bit
// datapath control word per cycle while stepping through EXEC/EXEC2.
module legv8_control_sequencer
    import legv8_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [93:0] control_word,
    output logic        illegal,
    output logic        halted
);
    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        zlat_q, zlat_d;
    logic        illegal_q, illegal_d;
    op_e         op;
    ctrl_t       cw;
    logic        cond_taken;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  movz_sh;
    logic [63:0] k_imm12, k_addr9, k_br26, k_br19, k_movz;

    assign op      = decode_op(ir_q);
    assign rd      = ir_q[4:0];
    assign rn      = ir_q[9:5];
    assign rm      = ir_q[20:16];
    assign movz_sh = {ir_q[22:21], 4'b0000};
    assign k_imm12 = {52'd0, ir_q[21:10]};
    assign k_addr9 = {{55{ir_q[20]}}, ir_q[20:12]};
    assign k_br26  = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
    assign k_br19  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
    assign k_movz  = {48'd0, ir_q[20:5]} << movz_sh;

    legv8_cond_eval u_cond_eval (
        .cond_i  (ir_q[3:0]),
        .flags_i (status[4:1]),
        .taken_o (cond_taken)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            zlat_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            zlat_q    <= zlat_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        zlat_d    = zlat_q;
        illegal_d = illegal_q;
        cw        = '0;
        unique case (state_q)
            StFetch: begin
                ir_d    = instruction;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpAdd, OpSub, OpAnd, OpOrr, OpAdds, OpSubs, OpAddi, OpSubi: begin
                        cw.da     = rd;
                        cw.sa     = rn;
                        cw.en_alu = 1'b1;
                        cw.wr     = 1'b1;
                        cw.ps     = PsInc;
                        cw.sl     = (op == OpAdds) || (op == OpSubs);
                        if (op == OpAddi || op == OpSubi) begin
                            cw.bsel = 1'b1;
                            cw.k    = k_imm12;
                        end else begin
                            cw.sb = rm;
                        end
                        unique case (op)
                            OpAdd, OpAdds, OpAddi: cw.fs = FsAdd;
                            OpSub, OpSubs, OpSubi: cw.fs = FsSub;
                            OpAnd:                 cw.fs = FsAnd;
                            default:               cw.fs = FsOrr;
                        endcase
                    end
                    OpMovz: begin
                        cw.da     = rd;
                        cw.bsel   = 1'b1;
                        cw.k      = k_movz;
                        cw.fs     = FsPassB;
                        cw.en_alu = 1'b1;
                        cw.wr     = 1'b1;
                        cw.ps     = PsInc;
                    end
                    OpLdur, OpStur: begin
                        cw.sa   = rn;
                        cw.bsel = 1'b1;
                        cw.k    = k_addr9;
                        cw.fs   = FsAdd;
                        cw.ps   = PsInc;
                        if (op == OpLdur) begin
                            cw.en_mem = 1'b1;
                            cw.wr     = 1'b1;
                            cw.da     = rd;
                        end else begin
                            cw.sb = rd;
                            cw.wm = 1'b1;
                        end
                    end
                    OpB: begin
                        cw.k  = k_br26;
                        cw.ps = PsRel;
                    end
                    OpBr: begin
                        cw.sa = rn;
                        cw.ps = PsReg;
                    end
                    OpBl: begin
                        // Link: PC (still held) is driven onto the bus into X30.
                        cw.en_pc = 1'b1;
                        cw.da    = 5'd30;
                        cw.wr    = 1'b1;
                        state_d  = StExec2;
                    end
                    OpCbz, OpCbnz: begin
                        cw.sb   = rd;
                        cw.fs   = FsPassB;
                        zlat_d  = status[0];
                        state_d = StExec2;
                    end
                    OpBcond: begin
                        if (cond_taken) begin
                            cw.k  = k_br19;
                            cw.ps = PsRel;
                        end else begin
                            cw.ps = PsInc;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        if (HALT_ON_ILLEGAL) state_d = StHalt;
                        else                 cw.ps   = PsInc;
                    end
                endcase
            end
            StExec2: begin
                state_d = StFetch;
                if (op == OpBl) begin
                    cw.k  = k_br26;
                    cw.ps = PsRel;
                end else if ((op == OpCbz && zlat_q) || (op == OpCbnz && !zlat_q)) begin
                    cw.k  = k_br19;
                    cw.ps = PsRel;
                end else begin
                    cw.ps = PsInc;
                end
            end
            StHalt: state_d = StHalt;
        endcase
    end

    assign control_word = cw;
    assign illegal      = illegal_q;
    assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Self-checking bench for legv8_control_sequencer: directed ISA cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_legv8_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic [4:0]  status = '0;
    logic [93:0] control_word;
    logic        illegal;
    logic        halted;

    int tests_run    = 0;
    int tests_failed = 0;

    legv8_control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .status       (status),
        .control_word (control_word),
        .illegal      (illegal),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Flag byte order: {EN_PC, EN_Mem, EN_ALU, PCsel, Bsel, SL, WM, WR}
    localparam logic [7:0] FlagPc   = 8'h80;
    localparam logic [7:0] FlagMem  = 8'h40;
    localparam logic [7:0] FlagAlu  = 8'h20;
    localparam logic [7:0] FlagBsel = 8'h08;
    localparam logic [7:0] FlagSl   = 8'h04;
    localparam logic [7:0] FlagWm   = 8'h02;
    localparam logic [7:0] FlagWr   = 8'h01;

    typedef enum int {
        KAdd, KSub, KAnd, KOrr, KAdds, KSubs, KLdur, KStur, KBr,
        KAddi, KSubi, KMovz, KCbz, KCbnz, KBcond, KB, KBl, KIll
    } kind_e;

    localparam int NumKinds = 17;
    localparam int TabW [NumKinds] = '{11, 11, 11, 11, 11, 11, 11, 11, 11, 10, 10, 9, 8, 8, 8, 6, 6};
    localparam int TabO [NumKinds] = '{
        'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000, 'b10101011000,
        'b11101011000, 'b11111000010, 'b11111000000, 'b11010110000,
        'b1001000100, 'b1101000100, 'b110100101,
        'b10110100, 'b10110101, 'b01010100, 'b000101, 'b100101
    };

    function automatic logic [93:0] mk(input logic [63:0] k, input logic [7:0] flags,
                                       input logic [1:0] ps, input logic [4:0] fs,
                                       input logic [4:0] sb, input logic [4:0] sa,
                                       input logic [4:0] da);
        return {k, flags, ps, fs, sb, sa, da};
    endfunction

    function automatic kind_e decode(input logic [31:0] ins);
        int widths [5] = '{11, 10, 9, 8, 6};
        for (int wi = 0; wi < 5; wi++)
            for (int k = 0; k < NumKinds; k++)
                if (TabW[k] == widths[wi] && int'(ins >> (32 - widths[wi])) == TabO[k])
                    return kind_e'(k);
        return KIll;
    endfunction

    // Expected EXEC (and EXEC2) words for one instruction given the status seen in EXEC.
    function automatic void model(input logic [31:0] ins, input logic [4:0] st, output int n,
                                  output logic [93:0] e1, output logic [93:0] e2);
        kind_e           k;
        logic [4:0]      rd, rn, rm, fs;
        longint          off26, off19, a9;
        longint unsigned imm;
        logic [3:0]      cnd;
        bit              base, taken;
        k     = decode(ins);
        rd    = ins[4:0];
        rn    = ins[9:5];
        rm    = ins[20:16];
        off26 = $signed(ins[25:0]);
        off26 = off26 * 4;
        off19 = $signed(ins[23:5]);
        off19 = off19 * 4;
        a9    = $signed(ins[20:12]);
        cnd   = ins[3:0];
        case (cnd[3:1])
            3'd0:    base = st[1];
            3'd1:    base = st[3];
            3'd2:    base = st[2];
            3'd3:    base = st[4];
            3'd4:    base = st[3] && !st[1];
            3'd5:    base = (st[2] == st[4]);
            3'd6:    base = !st[1] && (st[2] == st[4]);
            default: base = 1'b1;
        endcase
        taken = (cnd[0] && cnd != 4'd15) ? !base : base;
        case (k)
            KAdd, KAdds, KAddi: fs = 5'b01000;
            KSub, KSubs, KSubi: fs = 5'b01011;
            KAnd:               fs = 5'b00000;
            default:            fs = 5'b00100;
        endcase
        n  = 1;
        e1 = '0;
        e2 = '0;
        case (k)
            KAdd, KSub, KAnd, KOrr:
                e1 = mk(0, FlagAlu | FlagWr, 2'b01, fs, rm, rn, rd);
            KAdds, KSubs:
                e1 = mk(0, FlagAlu | FlagWr | FlagSl, 2'b01, fs, rm, rn, rd);
            KAddi, KSubi:
                e1 = mk(64'(ins[21:10]), FlagAlu | FlagBsel | FlagWr, 2'b01, fs, 0, rn, rd);
            KMovz: begin
                imm = ins[20:5];
                imm = imm << (16 * int'(ins[22:21]));
                e1  = mk(imm, FlagAlu | FlagBsel | FlagWr, 2'b01, 5'b10000, 0, 0, rd);
            end
            KLdur: e1 = mk(a9, FlagMem | FlagBsel | FlagWr, 2'b01, 5'b01000, 0, rn, rd);
            KStur: e1 = mk(a9, FlagBsel | FlagWm, 2'b01, 5'b01000, rd, rn, 0);
            KB:    e1 = mk(off26, 0, 2'b11, 0, 0, 0, 0);
            KBr:   e1 = mk(0, 0, 2'b10, 0, 0, rn, 0);
            KBl: begin
                n  = 2;
                e1 = mk(0, FlagPc | FlagWr, 2'b00, 0, 0, 0, 5'd30);
                e2 = mk(off26, 0, 2'b11, 0, 0, 0, 0);
            end
            KCbz, KCbnz: begin
                n     = 2;
                e1    = mk(0, 0, 2'b00, 5'b10000, rd, 0, 0);
                taken = st[0] ^ (k == KCbnz);
                e2    = taken ? mk(off19, 0, 2'b11, 0, 0, 0, 0) : mk(0, 0, 2'b01, 0, 0, 0, 0);
            end
            KBcond: e1 = taken ? mk(off19, 0, 2'b11, 0, 0, 0, 0) : mk(0, 0, 2'b01, 0, 0, 0, 0);
            default: e1 = '0;
        endcase
    endfunction

    // Start just after a negedge with the DUT in FETCH; ends at the negedge after the
    // instruction's last cycle, so the DUT is back in FETCH.
    task automatic issue(input logic [31:0] ins, input logic [4:0] s1, input logic [4:0] s2,
                         input int n, output logic [93:0] w0, output logic [93:0] w1,
                         output logic [93:0] w2);
        instruction = ins;
        status      = 5'($urandom);
        #1 w0 = control_word;
        @(negedge clock);
        status = s1;
        #1 w1 = control_word;
        w2 = '0;
        if (n == 2) begin
            @(negedge clock);
            status = s2;
            #1 w2 = control_word;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        tests_run++;
        if (control_word !== 94'd0) begin
            tests_failed++;
            $display("FAIL reset_word: got %h expected 0", control_word);
        end
        tests_run++;
        if (illegal !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got illegal=%b halted=%b expected 0 0", illegal, halted);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_addi();
        logic [93:0] w0, w1, w2, exp;
        issue(32'h910017E1, 5'd0, 5'd0, 1, w0, w1, w2);
        tests_run++;
        if (w0 !== 94'd0) begin
            tests_failed++;
            $display("FAIL addi_fetch: got %h expected 0", w0);
        end
        exp = mk(64'd5, FlagAlu | FlagBsel | FlagWr, 2'b01, 5'b01000, 5'd0, 5'd31, 5'd1);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL addi_exec: got %h expected %h", w1, exp);
        end
    endtask

    task automatic test_flags_branch();
        logic [93:0] w0, w1, w2, exp;
        issue(32'hEB010022, 5'd0, 5'd0, 1, w0, w1, w2);
        exp = mk(64'd0, FlagAlu | FlagWr | FlagSl, 2'b01, 5'b01011, 5'd1, 5'd1, 5'd2);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL subs_exec: got %h expected %h", w1, exp);
        end
        issue(32'h54000040, 5'b00010, 5'd0, 1, w0, w1, w2);
        exp = mk(64'd8, 8'd0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL beq_taken: got %h expected %h", w1, exp);
        end
        issue(32'h54000040, 5'b11101, 5'b00010, 1, w0, w1, w2);
        exp = mk(64'd0, 8'd0, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL beq_not_taken: got %h expected %h", w1, exp);
        end
    endtask

    task automatic test_cbz();
        logic [93:0] w0, w1, w2, exp;
        // status[0] flips in EXEC2 to show the decision uses the latched value.
        issue(32'hB4FFFFE3, 5'b00001, 5'b00000, 2, w0, w1, w2);
        exp = mk(64'd0, 8'd0, 2'b00, 5'b10000, 5'd3, 5'd0, 5'd0);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL cbz_exec1: got %h expected %h", w1, exp);
        end
        exp = mk(64'hFFFF_FFFF_FFFF_FFFC, 8'd0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if (w2 !== exp) begin
            tests_failed++;
            $display("FAIL cbz_taken: got %h expected %h", w2, exp);
        end
        issue(32'hB4FFFFE3, 5'b00000, 5'b00001, 2, w0, w1, w2);
        exp = mk(64'd0, 8'd0, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if (w2 !== exp) begin
            tests_failed++;
            $display("FAIL cbz_not_taken: got %h expected %h", w2, exp);
        end
    endtask

    task automatic test_bl_stur();
        logic [93:0] w0, w1, w2, exp;
        issue(32'h94000004, 5'd0, 5'd0, 2, w0, w1, w2);
        exp = mk(64'd0, FlagPc | FlagWr, 2'b00, 5'd0, 5'd0, 5'd0, 5'd30);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL bl_link: got %h expected %h", w1, exp);
        end
        exp = mk(64'd16, 8'd0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if (w2 !== exp) begin
            tests_failed++;
            $display("FAIL bl_branch: got %h expected %h", w2, exp);
        end
        issue(32'hF81F80A4, 5'd0, 5'd0, 1, w0, w1, w2);
        exp = mk(64'hFFFF_FFFF_FFFF_FFF8, FlagBsel | FlagWm, 2'b01, 5'b01000, 5'd4, 5'd5, 5'd0);
        tests_run++;
        if (w1 !== exp) begin
            tests_failed++;
            $display("FAIL stur_exec: got %h expected %h", w1, exp);
        end
    endtask

    task automatic test_random();
        logic [93:0] w0, w1, w2, e1, e2;
        logic [31:0] ins, r;
        logic [4:0]  s1, s2;
        int          k, n;
        for (int i = 0; i < 200; i++) begin
            k   = int'($urandom_range(0, NumKinds - 1));
            r   = $urandom;
            ins = (32'(TabO[k]) << (32 - TabW[k])) | (r & ((32'd1 << (32 - TabW[k])) - 32'd1));
            s1  = 5'($urandom);
            s2  = 5'($urandom);
            model(ins, s1, n, e1, e2);
            issue(ins, s1, s2, n, w0, w1, w2);
            tests_run++;
            if (w0 !== 94'd0 || w1 !== e1) begin
                tests_failed++;
                $display("FAIL rand_exec ins=%h st=%b: got %h/%h expected 0/%h",
                         ins, s1, w0, w1, e1);
            end
            if (n == 2) begin
                tests_run++;
                if (w2 !== e2) begin
                    tests_failed++;
                    $display("FAIL rand_exec2 ins=%h st=%b: got %h expected %h", ins, s1, w2, e2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_bl();
        logic [93:0] w0, w1, w2, exp;
        instruction = 32'h94000004;
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (control_word !== 94'd0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_bl: got %h halted=%b expected 0 0", control_word, halted);
        end
        @(negedge clock);
        reset = 1'b1;
        issue(32'h910017E1, 5'd0, 5'd0, 1, w0, w1, w2);
        exp = mk(64'd5, FlagAlu | FlagBsel | FlagWr, 2'b01, 5'b01000, 5'd0, 5'd31, 5'd1);
        tests_run++;
        if (w0 !== 94'd0 || w1 !== exp) begin
            tests_failed++;
            $display("FAIL after_reset_fetch: got %h/%h expected 0/%h", w0, w1, exp);
        end
    endtask

    task automatic test_illegal();
        logic [93:0] w0, w1, w2;
        issue(32'hFFFF_FFFF, 5'd0, 5'd0, 1, w0, w1, w2);
        #1;
        tests_run++;
        if (w1 !== 94'd0 || illegal !== 1'b1 || halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_halt: got word=%h illegal=%b halted=%b expected 0 1 1",
                     w1, illegal, halted);
        end
        instruction = 32'h8B020020;
        repeat (3) @(negedge clock);
        #1;
        tests_run++;
        if (control_word !== 94'd0 || halted !== 1'b1 || illegal !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_stays: got word=%h illegal=%b halted=%b expected 0 1 1",
                     control_word, illegal, halted);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (illegal !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_clear: got illegal=%b halted=%b expected 0 0", illegal, halted);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_flags_branch();
        test_cbz();
        test_bl_stur();
        test_random();
        test_reset_mid_bl();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
